// File: rtl/alu_pkg.sv
// Shared types for the ALU request scheduler: operand widths, opcodes,
// the ALU command/response records and the scheduler state encoding.
package alu_pkg;

    localparam int srcwidth = 8;
    localparam int dstwidth = 16;

    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_MEAN = 3'b001;

    typedef struct packed {
        logic       vld;
        logic [2:0] op;
    } alu_cmd_t;

    typedef struct packed {
        logic                err;
        logic [dstwidth-1:0] out;
        logic [srcwidth-1:0] rem;
    } alu_rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } sched_state_t;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MEAN: op_legal = 1'b1;
            default:                                 op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_req_sched_if.sv
// Requester, ALU and response channels of the scheduler. slave is the
// scheduler's view; master is the environment (requesters, ALU, consumer).
interface alu_req_sched_if #(
    parameter int NREQ = 4,
    parameter int SRCW = alu_pkg::srcwidth,
    parameter int DSTW = alu_pkg::dstwidth,
    parameter int IDW  = $clog2(NREQ)
);
    import alu_pkg::*;

    logic [NREQ-1:0]      req_vld;
    logic [NREQ-1:0]      req_rdy;
    logic [3*NREQ-1:0]    req_op;
    logic [SRCW*NREQ-1:0] req_a;
    logic [SRCW*NREQ-1:0] req_b;

    alu_cmd_t             alu_cmd;
    logic [SRCW-1:0]      alu_a;
    logic [SRCW-1:0]      alu_b;
    logic                 alu_done;
    logic [DSTW-1:0]      alu_out;
    logic [SRCW-1:0]      alu_rem;

    logic                 rsp_vld;
    logic                 rsp_rdy;
    logic [IDW-1:0]       rsp_id;
    logic [DSTW-1:0]      rsp_out;
    logic [SRCW-1:0]      rsp_rem;
    logic                 rsp_err;

    modport slave (
        input  req_vld, req_op, req_a, req_b, alu_done, alu_out, alu_rem, rsp_rdy,
        output req_rdy, alu_cmd, alu_a, alu_b, rsp_vld, rsp_id, rsp_out, rsp_rem, rsp_err
    );

    modport master (
        output req_vld, req_op, req_a, req_b, alu_done, alu_out, alu_rem, rsp_rdy,
        input  req_rdy, alu_cmd, alu_a, alu_b, rsp_vld, rsp_id, rsp_out, rsp_rem, rsp_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after
// ptr (wrapping) wins. The caller owns and advances ptr.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);

    // Scan farthest-from-ptr first so the nearest requester overwrites last.
    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j[IDW-1:0]]) begin
                gnt                = '0;
                gnt[j[IDW-1:0]]    = 1'b1;
                gnt_idx            = j[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_req_sched.sv
// Shares one multi-cycle ALU among NREQ requesters, one command at a time.
// IDLE grant/latch | ISSUE cmd pulse | WAIT done or watchdog | RESP hold until accepted
module alu_req_sched
    import alu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int SRCW    = srcwidth,
    parameter int DSTW    = dstwidth,
    parameter int TIMEOUT = 32
) (
    input logic            clk,
    input logic            rst,
    alu_req_sched_if.slave bus
);

    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = $clog2(TIMEOUT + 1);

    sched_state_t    state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  id_q;
    alu_cmd_t        cmd_q;
    logic [SRCW-1:0] a_q;
    logic [SRCW-1:0] b_q;
    logic [CNTW-1:0] cnt_q;
    logic            rsp_vld_q;
    alu_rsp_t        rsp_q;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [2:0]      op_sel;
    logic [SRCW-1:0] a_sel;
    logic [SRCW-1:0] b_sel;
    logic            grant_en;
    logic            cmd_ok;
    logic [DSTW-1:0] done_out;

    rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
        .req     (bus.req_vld),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                op_sel = bus.req_op[3*i +: 3];
                a_sel  = bus.req_a[SRCW*i +: SRCW];
                b_sel  = bus.req_b[SRCW*i +: SRCW];
            end
        end
    end

    // Grants only in IDLE; reset also masks the combinational grant.
    assign grant_en    = (state_q == ST_IDLE) && !rst;
    assign bus.req_rdy = grant_en ? gnt : '0;
    assign cmd_ok      = op_legal(op_sel) && !((op_sel == OP_DIV) && (b_sel == '0));
    assign done_out    = bus.alu_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            cmd_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        id_q  <= gnt_idx;
                        ptr_q <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                        cnt_q <= '0;
                        if (cmd_ok) begin
                            a_q     <= a_sel;
                            b_q     <= b_sel;
                            cmd_q   <= '{vld: 1'b1, op: op_sel};
                            state_q <= ST_ISSUE;
                        end else begin
                            rsp_q     <= '{err: 1'b1, out: '0, rem: '0};
                            rsp_vld_q <= 1'b1;
                            state_q   <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    cmd_q   <= '0;
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.alu_done) begin
                        rsp_q     <= '{err: 1'b0, out: done_out, rem: bus.alu_rem};
                        rsp_vld_q <= 1'b1;
                        state_q   <= ST_RESP;
                    end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                        rsp_q     <= '{err: 1'b1, out: '0, rem: '0};
                        rsp_vld_q <= 1'b1;
                        state_q   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_rdy) begin
                        rsp_vld_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.alu_cmd = cmd_q;
    assign bus.alu_a   = a_q;
    assign bus.alu_b   = b_q;
    assign bus.rsp_vld = rsp_vld_q;
    assign bus.rsp_id  = id_q;
    assign bus.rsp_out = rsp_q.out;
    assign bus.rsp_rem = rsp_q.rem;
    assign bus.rsp_err = rsp_q.err;

endmodule

// File: doc/alu_req_sched.md
# alu_req_sched

Scheduler that shares one multi-cycle ALU (add/sub/mul/div/mean) among `NREQ` requesters. It sits between the requester-side command ports and the ALU datapath. It grants one requester at a time in round-robin order, issues a single `alu_cmd_t` pulse, waits for ALU completion or a watchdog timeout, and returns a tagged response over a valid/ready channel.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `SRCW`, 8: operand width, equals package `srcwidth`
- `DSTW`, 16: result width, equals package `dstwidth`
- `TIMEOUT`, 32: maximum cycles in WAIT before an aborted response
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_vld` in NREQ: per-requester command valid
- `req_rdy` out NREQ: per-requester accept; one-hot or zero
- `req_op` in NREQ*3: opcode per requester, slice i = [3i+2:3i]
- `req_a`, `req_b` in NREQ*SRCW: operands per requester
- `alu_cmd` out alu_cmd_t: {vld, op} to the ALU; vld is a one-cycle pulse
- `alu_a`, `alu_b` out SRCW: operands, held stable from ISSUE through WAIT
- `alu_done` in 1: ALU result valid, one-cycle pulse
- `alu_out` in DSTW, `alu_rem` in SRCW: ALU result and remainder
- `rsp_vld` out 1, `rsp_rdy` in 1: response handshake
- `rsp_id` out $clog2(NREQ): index of the requester that issued the command
- `rsp_out` out DSTW, `rsp_rem` out SRCW, `rsp_err` out 1: response payload

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE transitions:
  - Round-robin search starts at `ptr`. The first i with `req_vld[i]` gets `req_rdy[i]=1` combinationally.
  - On the handshake, latch id, op, a and b, then set `ptr = (i+1) mod NREQ`.
  - Legal op (100, 101, 010, 011, 001) and not divide-by-zero: go to ISSUE.
  - Illegal op (000, 110, 111) or div with b==0: go to RESP with err=1, out=0, rem=0. The ALU is not touched.
- ISSUE: `alu_cmd.vld=1` with the latched op for exactly one cycle, then WAIT. The watchdog counter is cleared.
- WAIT:
  - On `alu_done`, capture out/rem with err=0 and go to RESP.
  - Counter reaching TIMEOUT-1 without done: go to RESP with err=1, out=0, rem=0.
- RESP: `rsp_vld=1` with payload held stable until `rsp_rdy`, then IDLE. No grant is issued in RESP.
- `alu_done` outside WAIT (late or stray) is ignored.
- Reset values: `req_rdy=0`, `alu_cmd=0`, `alu_a/alu_b=0`, `rsp_vld=0`, `rsp_id/out/rem/err=0`, `ptr=0`, counter=0.
- Reset mid-operation: asynchronous return to IDLE. Any in-flight ALU result is dropped and `ptr` resets to 0.

## Timing
- At most one command is outstanding; no pipelining across requests.
- Request handshake at cycle T:
  - `alu_cmd.vld` at T+1.
  - Earliest `alu_done` at T+2.
  - `rsp_vld` at the cycle after done, so minimum T+3.
- Error path (illegal op / div by zero): `rsp_vld` at T+1.
- Timeout path: `rsp_vld` at T+1+TIMEOUT.
- Back-to-back: the next grant is possible in the cycle after the `rsp_vld&&rsp_rdy` handshake.
- `req_rdy` is zero in every state except IDLE. A requester may drop `req_vld` without penalty before its grant.
- `rsp_rdy` low stalls indefinitely in RESP and blocks all requesters.

## Structure
- Add to `alu_pkg`:
  - Opcode localparams `OP_ADD=3'b100`, `OP_SUB=3'b101`, `OP_MUL=3'b010`, `OP_DIV=3'b011`, `OP_MEAN=3'b001`.
  - Function `op_legal(op)`.
  - Packed struct `alu_rsp_t` {err, out[dstwidth], rem[srcwidth]}.
  - Enum `sched_state_t`.
- Sub-module `rr_arbiter`: parameter N; inputs req[N], ptr; outputs one-hot gnt[N], gnt_idx. Purely combinational priority rotation; the scheduler owns `ptr`.

## Test plan
- Single add: req0 op=100, a=8'h12, b=8'h34; ALU done 2 cycles after issue with 16'h0046 -> `rsp_id=0`, `rsp_out=16'h0046`, `err=0`; check cycle counts against the Timing section.
- Round robin: `req_vld=4'b1111` held, each command answered immediately -> grants in order 0,1,2,3,0. With req1 only and `ptr=2`, req1 is granted next.
- Errors: op=3'b111 -> `rsp_vld` at T+1, `err=1`, `alu_cmd.vld` never asserted. Div a=8'd9, b=0 -> same result.
- Timeout: ALU never returns done with TIMEOUT=32 -> `rsp_vld` at T+33 with `err=1`. A later stray `alu_done` in IDLE is ignored.
- Backpressure and reset: `rsp_rdy=0` for 10 cycles -> payload stable, `req_rdy=0` throughout. Asserting `rst` during WAIT -> all outputs 0 immediately and `ptr=0`; the subsequent `alu_done` produces no response.
